// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for data-memory loads and stores.
// Accepts one request at a time over valid/ready, waits WAIT_CYCLES, then
// presents read data or a store acknowledge until the initiator takes it.
// Optional feature: define MISALIGN_CHECK_EN to reject accesses whose byte
// address is not doubleword aligned (otherwise low address bits are ignored).
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 8);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, next_state;
  logic [3:0] cnt, cnt_next;
  logic ready_en;
  logic lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [63:0] mem [DEPTH];

  logic accept;
  logic commit;
  logic acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [63:0] acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic acc_misalign;
  logic acc_err;

  assign req_ready  = ready_en && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // Select the live request in IDLE (zero-wait commit) or the latched one later
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx = acc_addr[IDX_W+2:3];

`ifdef MISALIGN_CHECK_EN
  assign acc_misalign = (acc_addr[2:0] != 3'b000);
`else
  assign acc_misalign = 1'b0;
`endif

  assign acc_err = (acc_addr >= LIMIT) || acc_misalign;

  // Next-state and wait-counter logic
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = WAIT_INIT;
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign commit = (next_state == RESP) && (state != RESP);

  // State, counter and the ready-after-reset enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready_en <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      ready_en <= 1'b1;
    end
  end

  // Capture the request on accept so later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Doubleword array: stores commit on the edge entering RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Response registers: sampled on the edge entering RESP, held until handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_write || acc_err) ? 64'd0 : mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: table-driven accesses on a WAIT_CYCLES=2
// instance plus hand-written backpressure, mid-op reset and zero-wait sequences.
module tb_dmem_responder;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_z = 1'b1;
  logic sel = 1'b0;
  int   cur_wait = 2;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b0;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [63:0] a_resp_rdata;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [63:0] z_resp_rdata;

  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  vec_t vecs[10];

  dmem_responder #(.DEPTH(64), .ADDR_W(64), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset_a),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH(64), .ADDR_W(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset_z),
    .req_valid(req_valid), .req_ready(z_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  assign req_ready  = sel ? z_req_ready  : a_req_ready;
  assign resp_valid = sel ? z_resp_valid : a_resp_valid;
  assign resp_err   = sel ? z_resp_err   : a_resp_err;
  assign resp_rdata = sel ? z_resp_rdata : a_resp_rdata;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One full transaction with resp_ready held high; checks latency and response
  task automatic applyStimulus(input vec_t v, input string tag);
    int waitn;
    int lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.write;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    resp_ready = 1'b1;
    waitn = 0;
    while (!req_ready && waitn < 20) begin
      @(negedge clk);
      waitn++;
    end
    if (!req_ready) begin
      checkOutput({tag, " accept timeout"}, 64'd0, 64'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = ~v.write;
      req_addr  = ~v.addr;
      req_wdata = ~v.wdata;
      lat = 1;
      while (!resp_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput({tag, " latency"}, 64'(lat), 64'(cur_wait + 1));
      checkOutput({tag, " err"}, 64'(resp_err), 64'(v.exp_err));
      checkOutput({tag, " rdata"}, resp_rdata, v.exp_rdata);
      checkOutput({tag, " req_ready in resp"}, 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, " resp_valid after handshake"}, 64'(resp_valid), 64'd0);
    end
  endtask

  initial begin
    int lat;
    int acc;
    logic [63:0] held;

    vecs[0] = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 64'h10,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 64'h200, 64'h1111_2222_3333_4444, 1'b1, 64'h0};
    vecs[3] = '{1'b0, 64'h1F8, 64'h0,                 1'b0, 64'h0};
`ifdef MISALIGN_CHECK_EN
    vecs[4] = '{1'b0, 64'h13,  64'h0,                 1'b1, 64'h0};
`else
    vecs[4] = '{1'b0, 64'h13,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
`endif
    vecs[5] = '{1'b1, 64'h1F8, 64'h01234567_89ABCDEF, 1'b0, 64'h0};
    vecs[6] = '{1'b0, 64'h1F8, 64'h0,                 1'b0, 64'h01234567_89ABCDEF};
    vecs[7] = '{1'b0, 64'h210, 64'h0,                 1'b1, 64'h0};
    vecs[8] = '{1'b1, 64'h08,  64'h0000_0000_0000_AAAA, 1'b0, 64'h0};
    vecs[9] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,  1'b1, 64'h0};

    // Reset state while asserted
    #1;
    reset_a = 1'b0;
    reset_z = 1'b0;
    #2;
    checkOutput("reset req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset resp_err", 64'(resp_err), 64'd0);
    checkOutput("reset resp_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    reset_a = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready after release", 64'(req_ready), 64'd1);

    // Table-driven accesses
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response held stable, a waiting request is not accepted
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'h10;
    req_wdata  = 64'h0;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_write = 1'b1;
    req_addr  = 64'h08;
    req_wdata = 64'h5555_6666_7777_8888;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp latency", 64'(lat), 64'd3);
    held = 64'hDEADBEEF_CAFEF00D;
    checkOutput("bp rdata", resp_rdata, held);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d resp_valid", k), 64'(resp_valid), 64'd1);
      checkOutput($sformatf("bp%0d rdata", k), resp_rdata, held);
      checkOutput($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp handoff resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("bp handoff req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp queued accepted", 64'(req_ready), 64'd0);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp store latency", 64'(lat), 64'd3);
    checkOutput("bp store err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    applyStimulus('{1'b0, 64'h08, 64'h0, 1'b0, 64'h5555_6666_7777_8888}, "bp readback");

    // Reset during WAIT abandons a pending store and clears the array
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h08;
    req_wdata = 64'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("midrst accepted", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset_a = 1'b0;
    #1;
    checkOutput("midrst resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("midrst req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("midrst held resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset_a = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst ready after release", 64'(req_ready), 64'd1);
    applyStimulus('{1'b0, 64'h08, 64'h0, 1'b0, 64'h0}, "midrst load");
    applyStimulus('{1'b0, 64'h1F8, 64'h0, 1'b0, 64'h0}, "midrst load2");

    // Zero-wait instance
    @(negedge clk);
    reset_a  = 1'b0;
    sel      = 1'b1;
    cur_wait = 0;
    reset_z  = 1'b1;
    @(posedge clk); #1;
    checkOutput("zw ready after release", 64'(req_ready), 64'd1);
    applyStimulus('{1'b0, 64'h00, 64'h0, 1'b0, 64'h0}, "zw load0");
    applyStimulus('{1'b1, 64'h00, 64'hFEED_FACE_0BAD_BEEF, 1'b0, 64'h0}, "zw store0");
    applyStimulus('{1'b0, 64'h00, 64'h0, 1'b0, 64'hFEED_FACE_0BAD_BEEF}, "zw load0 again");

    // Back-to-back loads: one accept every two cycles
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'h00;
    resp_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("zw b2b accepts", 64'(acc), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
